// File: rtl/cam_pkg.sv
// cam_pkg: shared framebuffer geometry and capture FSM encoding
package cam_pkg;
    localparam int FB_W      = 320;
    localparam int FB_H      = 240;
    localparam int FB_DEPTH  = FB_W * FB_H;
    localparam int FB_ADDR_W = 19;
    localparam int PIX_W     = 12;
    typedef enum logic [1:0] {WAIT_VS, IN_VS, ACTIVE} cap_state_e;
endpackage

// File: rtl/cam_byte_pack.sv
// cam_byte_pack: pairs RGB444 camera bytes into registered 12-bit pixels
module cam_byte_pack
    import cam_pkg::*;
(
    input  logic             pclk,
    input  logic             rst_pclk,
    input  logic             href,
    input  logic             href_rise,
    input  logic [7:0]       data,
    output logic             pix_valid,
    output logic [PIX_W-1:0] pix
);
    logic             phase_q, phase_d, phase_eff;
    logic [3:0]       r_q, r_d;
    logic             pix_valid_q, pix_valid_d;
    logic [PIX_W-1:0] pix_q, pix_d;

    // phase restarts at every line start, so a dangling odd byte never pairs across lines
    always_comb begin
        phase_eff   = phase_q & ~href_rise;
        phase_d     = href ? ~phase_eff : phase_q;
        r_d         = (href && !phase_eff) ? data[3:0] : r_q;
        pix_valid_d = href && phase_eff;
        pix_d       = pix_valid_d ? {r_q, data} : pix_q;
    end

    // pixel assembly registers
    always_ff @(posedge pclk or posedge rst_pclk) begin
        if (rst_pclk) begin
            phase_q     <= 1'b0;
            r_q         <= '0;
            pix_valid_q <= 1'b0;
            pix_q       <= '0;
        end else begin
            phase_q     <= phase_d;
            r_q         <= r_d;
            pix_valid_q <= pix_valid_d;
            pix_q       <= pix_d;
        end
    end

    assign pix_valid = pix_valid_q;
    assign pix       = pix_q;
endmodule

// File: rtl/cam_capture.sv
// cam_capture: DVP camera capture with 2:1 decimation into a linear framebuffer
module cam_capture
    import cam_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int DECIMATE = 1,
    parameter int FB_W     = cam_pkg::FB_W
) (
    input  logic                 pclk,
    input  logic                 rst_pclk,
    input  logic                 cam_vsync,
    input  logic                 cam_href,
    input  logic [7:0]           cam_data,
    input  logic                 capture_en,
    output logic                 wr_en,
    output logic [FB_ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]     wr_data,
    output logic                 frame_done,
    output logic [7:0]           frame_cnt,
    output logic                 line_err
);
    localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
    localparam logic [8:0] V_LIM = 9'(V_ACTIVE);
    localparam logic [FB_ADDR_W-1:0] ADDR_MAX =
        FB_ADDR_W'(DECIMATE != 0 ? FB_W * (V_ACTIVE / 2) - 1 : H_ACTIVE * V_ACTIVE - 1);

    logic                 vs_q, vs_qq, href_q, href_qq;
    logic [7:0]           d_q;
    logic                 vs_rise, vs_fall, href_rise, href_fall;
    logic                 pix_valid, active, keep, in_range, do_wr, overrun;
    logic [PIX_W-1:0]     pix;
    cap_state_e           state_q, state_d;
    logic [9:0]           x_cnt_q, x_cnt_d;
    logic [8:0]           y_cnt_q, y_cnt_d;
    logic [FB_ADDR_W-1:0] addr_q, addr_d, wr_addr_q, wr_addr_d;
    logic [PIX_W-1:0]     wr_data_q, wr_data_d;
    logic [7:0]           frame_cnt_q, frame_cnt_d;
    logic                 wr_en_q, wr_en_d, frame_done_q, frame_done_d, line_err_q, line_err_d;

    // input registers plus a second delay for edge detection
    always_ff @(posedge pclk or posedge rst_pclk) begin
        if (rst_pclk) begin
            vs_q    <= 1'b0;
            vs_qq   <= 1'b0;
            href_q  <= 1'b0;
            href_qq <= 1'b0;
            d_q     <= '0;
        end else begin
            vs_q    <= cam_vsync;
            vs_qq   <= vs_q;
            href_q  <= cam_href;
            href_qq <= href_q;
            d_q     <= cam_data;
        end
    end

    cam_byte_pack u_pack (
        .pclk      (pclk),
        .rst_pclk  (rst_pclk),
        .href      (href_q),
        .href_rise (href_rise),
        .data      (d_q),
        .pix_valid (pix_valid),
        .pix       (pix)
    );

    // edges and the per-pixel write decision
    always_comb begin
        vs_rise   = vs_q & ~vs_qq;
        vs_fall   = ~vs_q & vs_qq;
        href_rise = href_q & ~href_qq;
        href_fall = ~href_q & href_qq;
        active    = state_q == ACTIVE;
        keep      = DECIMATE == 0 || (!x_cnt_q[0] && !y_cnt_q[0]);
        in_range  = x_cnt_q < H_LIM && y_cnt_q < V_LIM;
        do_wr     = active && pix_valid && in_range && keep;
        overrun   = active && pix_valid && !in_range;
    end

    // frame FSM, saturating position counters and the linear write address
    always_comb begin
        state_d      = state_q;
        x_cnt_d      = href_rise ? '0 : (pix_valid && x_cnt_q != '1) ? x_cnt_q + 10'd1 : x_cnt_q;
        y_cnt_d      = (active && href_fall && y_cnt_q != '1) ? y_cnt_q + 9'd1 : y_cnt_q;
        addr_d       = do_wr ? (addr_q == ADDR_MAX ? '0 : addr_q + 1'b1) : addr_q;
        frame_cnt_d  = frame_cnt_q;
        frame_done_d = 1'b0;
        line_err_d   = line_err_q | overrun;
        wr_en_d      = do_wr;
        wr_addr_d    = do_wr ? addr_q : wr_addr_q;
        wr_data_d    = do_wr ? pix : wr_data_q;
        case (state_q)
            WAIT_VS: if (vs_rise && capture_en) state_d = IN_VS;
            IN_VS: if (vs_fall) begin
                addr_d  = '0;
                x_cnt_d = '0;
                y_cnt_d = '0;
                state_d = ACTIVE;
            end
            ACTIVE: if (vs_rise) begin
                frame_done_d = 1'b1;
                frame_cnt_d  = frame_cnt_q + 8'd1;
                state_d      = capture_en ? IN_VS : WAIT_VS;
            end
            default: state_d = WAIT_VS;
        endcase
    end

    // state, counters and registered outputs
    always_ff @(posedge pclk or posedge rst_pclk) begin
        if (rst_pclk) begin
            state_q      <= WAIT_VS;
            x_cnt_q      <= '0;
            y_cnt_q      <= '0;
            addr_q       <= '0;
            frame_cnt_q  <= '0;
            frame_done_q <= 1'b0;
            line_err_q   <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            x_cnt_q      <= x_cnt_d;
            y_cnt_q      <= y_cnt_d;
            addr_q       <= addr_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_done_q <= frame_done_d;
            line_err_q   <= line_err_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;
    assign line_err   = line_err_q;
endmodule
